// File: rtl/dsky_key_pkg.sv
// dsky_key_pkg: shared keycode width, no-key code and debouncer state encoding
package dsky_key_pkg;
  localparam int KEY_W = 5;
  localparam logic [KEY_W-1:0] KEY_NONE = '0;
  typedef enum logic [2:0] {IDLE, PRESS, RUPT, RELEASE, RLSRUPT} key_st_e;
endpackage

// File: rtl/dsky_key_debouncer.sv
// dsky_key_debouncer: per-keyboard debounce FSM, channel register, rupt request and overrun flag
module dsky_key_debouncer
  import dsky_key_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int CNT_W = 3,
  parameter bit RLS_RUPT = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             jam_i,
  input  logic             tick_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic             ack_i,
  output logic             rupt_o,
  output logic [KEY_W-1:0] ch_o,
  output logic             ovr_o
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(DEBOUNCE_TICKS);
  key_st_e st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, press_cnt;
  logic [KEY_W-1:0] smp_q, smp_d, ch_q, ch_d;
  logic ovr_q, ovr_d, key_on;
  assign key_on = key_i != KEY_NONE;
  assign cnt_inc = (cnt_q == LIM) ? LIM : cnt_q + 1'b1;
  assign press_cnt = (st_q == PRESS && key_i == smp_q) ? cnt_inc : CNT_W'(1);
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    smp_d = smp_q;
    ch_d = ch_q;
    ovr_d = ovr_q;
    case (st_q)
      IDLE, PRESS: if (tick_i) begin
        if (!key_on) begin
          st_d = IDLE;
          cnt_d = '0;
        end else begin
          smp_d = key_i;
          cnt_d = press_cnt;
          st_d = (press_cnt == LIM) ? RUPT : PRESS;
          ch_d = (press_cnt == LIM) ? key_i : ch_q;
        end
      end
      RUPT: begin
        ovr_d = ovr_q | (tick_i & key_on & (key_i != ch_q));
        if (ack_i) begin
          st_d = RELEASE;
          cnt_d = '0;
        end
      end
      RELEASE: if (tick_i) begin
        cnt_d = key_on ? '0 : cnt_inc;
        if (!key_on && cnt_inc == LIM) begin
          st_d = RLS_RUPT ? RLSRUPT : IDLE;
          ch_d = RLS_RUPT ? KEY_NONE : ch_q;
          cnt_d = '0;
        end
      end
      RLSRUPT: st_d = ack_i ? IDLE : RLSRUPT;
      default: st_d = IDLE;
    endcase
  end
  // jam clears everything but the channel register, which only a true reset wipes
  always_ff @(posedge clk_i) begin
    if (rst_i || jam_i) begin
      st_q <= IDLE;
      cnt_q <= '0;
      smp_q <= KEY_NONE;
      ovr_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      smp_q <= smp_d;
      ovr_q <= ovr_d;
    end
    if (rst_i) ch_q <= KEY_NONE;
    else if (!jam_i) ch_q <= ch_d;
  end
  assign rupt_o = (st_q == RUPT) || (st_q == RLSRUPT);
  assign ch_o = ch_q;
  assign ovr_o = ovr_q;
endmodule

// File: rtl/dsky_key_rupt_source.sv
// dsky_key_rupt_source: two debounced DSKY keyboards raising KYRPT1/KYRPT2.
// DSKY_KEY_RELEASE_RUPT_EN adds a key-release rupt on keyboard 1.
module dsky_key_rupt_source
  import dsky_key_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLOCK,
  input  logic             rst,
  input  logic             TICK,
  input  logic             GOJAM,
  input  logic [KEY_W-1:0] KEY1,
  input  logic [KEY_W-1:0] KEY2,
  input  logic             KY1RST,
  input  logic             KY2RST,
  output logic             KYRPT1,
  output logic             KYRPT2,
  output logic [KEY_W-1:0] CH15,
  output logic [KEY_W-1:0] CH16,
  output logic             KOVR1,
  output logic             KOVR2
);
`ifdef DSKY_KEY_RELEASE_RUPT_EN
  localparam bit RLS1 = 1'b1;
`else
  localparam bit RLS1 = 1'b0;
`endif
  logic jam;
  assign jam = rst | GOJAM;
  dsky_key_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .CNT_W(CNT_W), .RLS_RUPT(RLS1)) u_kb1 (
    .clk_i(CLOCK), .rst_i(rst), .jam_i(jam), .tick_i(TICK), .key_i(KEY1), .ack_i(KY1RST),
    .rupt_o(KYRPT1), .ch_o(CH15), .ovr_o(KOVR1)
  );
  dsky_key_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .CNT_W(CNT_W), .RLS_RUPT(1'b0)) u_kb2 (
    .clk_i(CLOCK), .rst_i(rst), .jam_i(jam), .tick_i(TICK), .key_i(KEY2), .ack_i(KY2RST),
    .rupt_o(KYRPT2), .ch_o(CH16), .ovr_o(KOVR2)
  );
endmodule

// File: tb/tb_dsky_key_rupt_source.sv
// tb_dsky_key_rupt_source: scoreboard bench for the DSKY keyboard rupt source
module tb_dsky_key_rupt_source;
`ifdef DSKY_KEY_RELEASE_RUPT_EN
  localparam bit RLS = 1'b1;
`else
  localparam bit RLS = 1'b0;
`endif
  typedef struct {
    string tag;
    logic r1, r2;
    logic [4:0] c15, c16;
    logic o1, o2;
  } exp_t;
  logic CLOCK = 1'b0, rst = 1'b1, TICK = 1'b0, GOJAM = 1'b0, KY1RST = 1'b0, KY2RST = 1'b0;
  logic [4:0] KEY1 = '0, KEY2 = '0;
  logic KYRPT1, KYRPT2, KOVR1, KOVR2;
  logic [4:0] CH15, CH16;
  exp_t sb[$];
  exp_t nx;
  int total = 0, bad = 0;
  dsky_key_rupt_source dut (
    .CLOCK(CLOCK), .rst(rst), .TICK(TICK), .GOJAM(GOJAM), .KEY1(KEY1), .KEY2(KEY2),
    .KY1RST(KY1RST), .KY2RST(KY2RST), .KYRPT1(KYRPT1), .KYRPT2(KYRPT2),
    .CH15(CH15), .CH16(CH16), .KOVR1(KOVR1), .KOVR2(KOVR2)
  );
  always #5 CLOCK = ~CLOCK;
  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, obs, exp);
    end
  endtask
  function automatic exp_t ex(input string tag, input logic r1, input logic r2,
                              input logic [4:0] c15, input logic [4:0] c16,
                              input logic o1, input logic o2);
    exp_t e;
    e.tag = tag; e.r1 = r1; e.r2 = r2; e.c15 = c15; e.c16 = c16; e.o1 = o1; e.o2 = o2;
    return e;
  endfunction
  task automatic cyc(input bit t, input bit c, input exp_t e);
    exp_t p;
    TICK = t;
    if (c) sb.push_back(e);
    @(posedge CLOCK);
    #1;
    TICK = 1'b0;
    if (c) begin
      p = sb.pop_front();
      chk({p.tag, ".kyrpt1"}, 5'(KYRPT1), 5'(p.r1));
      chk({p.tag, ".kyrpt2"}, 5'(KYRPT2), 5'(p.r2));
      chk({p.tag, ".ch15"}, CH15, p.c15);
      chk({p.tag, ".ch16"}, CH16, p.c16);
      chk({p.tag, ".kovr1"}, 5'(KOVR1), 5'(p.o1));
      chk({p.tag, ".kovr2"}, 5'(KOVR2), 5'(p.o2));
    end
  endtask
  task automatic tk(input bit c, input exp_t e);
    cyc(1'b1, c, e);
    cyc(1'b0, 1'b0, e);
  endtask
  initial begin
    nx = ex("-", 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, ex("reset", 0, 0, 5'b00000, 5'b00000, 0, 0));
    rst = 1'b0;
    KEY1 = 5'b10001;
    for (int i = 1; i <= 4; i++)
      tk(1'b1, ex("k1_press", i == 4, 0, (i == 4) ? 5'b10001 : 5'b00000, 5'b00000, 0, 0));
    KEY2 = 5'b00101; tk(1'b1, ex("k2_bounce_a", 1, 0, 5'b10001, 5'b00000, 0, 0));
    KEY2 = 5'b00000; tk(1'b1, ex("k2_bounce_b", 1, 0, 5'b10001, 5'b00000, 0, 0));
    KEY2 = 5'b00101;
    for (int i = 1; i <= 4; i++)
      tk(1'b1, ex("k2_press", 1, i == 4, 5'b10001, (i == 4) ? 5'b00101 : 5'b00000, 0, 0));
    KEY1 = 5'b00011; tk(1'b1, ex("k1_overrun", 1, 1, 5'b10001, 5'b00101, 1, 0));
    KEY1 = 5'b10001; KEY2 = 5'b00000;
    GOJAM = 1'b1; cyc(1'b0, 1'b1, ex("gojam", 0, 0, 5'b10001, 5'b00101, 0, 0));
    GOJAM = 1'b0;
    for (int i = 1; i <= 3; i++) tk(1'b1, ex("k1_repress", 0, 0, 5'b10001, 5'b00101, 0, 0));
    KY1RST = 1'b1; cyc(1'b1, 1'b1, ex("ack_on_entry", 1, 0, 5'b10001, 5'b00101, 0, 0));
    cyc(1'b0, 1'b1, ex("ack_after_entry", 0, 0, 5'b10001, 5'b00101, 0, 0));
    KY1RST = 1'b0;
    for (int i = 1; i <= 10; i++) tk(1'b1, ex("k1_held", 0, 0, 5'b10001, 5'b00101, 0, 0));
    KEY1 = 5'b00000;
    for (int i = 1; i <= 4; i++)
      tk(1'b1, ex("k1_release", (i == 4) && RLS, 0, ((i == 4) && RLS) ? 5'b00000 : 5'b10001, 5'b00101, 0, 0));
    KY1RST = 1'b1; cyc(1'b0, 1'b1, ex("k1_release_ack", 0, 0, RLS ? 5'b00000 : 5'b10001, 5'b00101, 0, 0));
    KY1RST = 1'b0;
    KEY1 = 5'b01010;
    for (int i = 1; i <= 4; i++)
      tk(1'b1, ex("k1_idle_press", i == 4, 0, (i == 4) ? 5'b01010 : (RLS ? 5'b00000 : 5'b10001), 5'b00101, 0, 0));
    KEY2 = 5'b00111;
    tk(1'b0, nx);
    tk(1'b0, nx);
    rst = 1'b1; cyc(1'b0, 1'b1, ex("rst_mid_debounce", 0, 0, 5'b00000, 5'b00000, 0, 0));
    rst = 1'b0;
    for (int i = 1; i <= 4; i++)
      tk(1'b1, ex("post_rst_press", i == 4, i == 4, (i == 4) ? 5'b01010 : 5'b00000, (i == 4) ? 5'b00111 : 5'b00000, 0, 0));
    KY2RST = 1'b1; cyc(1'b0, 1'b1, ex("k2_ack", 1, 0, 5'b01010, 5'b00111, 0, 0));
    KY2RST = 1'b0;
    chk("sb_empty", 5'(sb.size()), 5'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dsky_key_rupt_source.md
Name: dsky_key_rupt_source

Overview:
- Requester end of the keyboard-interrupt path.
- Samples the 5-bit keycodes from the main DSKY (keyboard 1) and the nav DSKY (keyboard 2) and debounces them.
- Latches each debounced code into its input channel register (CH15 for keyboard 1, CH16 for keyboard 2), then raises KYRPT1/KYRPT2.
- Each request stays asserted until the rupt-service logic returns the KY1RST/KY2RST acknowledge.

Parameters:
- DEBOUNCE_TICKS, 4: consecutive equal TICK samples needed to accept a press, and to accept a release.
- CNT_W, 3: width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_TICKS.

Ports:
- CLOCK  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- TICK  in  1  one-CLOCK scaler strobe; debounce counters advance only when it is high.
- GOJAM  in  1  hardware restart; clears rupts and FSMs, keeps channel registers.
- KEY1  in  5  raw keycode, keyboard 1; 00000 = no key.
- KEY2  in  5  raw keycode, keyboard 2.
- KY1RST  in  1  acknowledge for KYRPT1; level, sampled each CLOCK.
- KY2RST  in  1  acknowledge for KYRPT2.
- KYRPT1  out  1  keyboard-1 rupt request.
- KYRPT2  out  1  keyboard-2 rupt request.
- CH15  out  5  last accepted keyboard-1 code.
- CH16  out  5  last accepted keyboard-2 code.
- KOVR1  out  1  sticky overrun, keyboard 1.
- KOVR2  out  1  sticky overrun, keyboard 2.

Behaviour:
- Interface: one clock (CLOCK); reset rst is synchronous and active-high.
- Reset (rst high at an edge): KYRPTx=0, CH15=CH16=00000, KOVRx=0, both FSMs in IDLE, counters 0.
- GOJAM: same as rst, except CH15/CH16 keep their values. rst takes precedence over GOJAM.
- The two keyboard channels are independent and identical.
- FSM per channel: IDLE, PRESS, RUPT, RELEASE.
- IDLE: on TICK with KEY≠0, capture the code into a sample register, set cnt=1, go to PRESS.
- PRESS (on TICK only):
  - KEY equal to the captured code: cnt++.
  - KEY≠0 but different: recapture, cnt=1.
  - KEY=0: go to IDLE.
  - When cnt reaches DEBOUNCE_TICKS: in that same edge load CHxx with the code, set KYRPTx=1, go to RUPT.
  - Latency from first sample to KYRPT: DEBOUNCE_TICKS TICKs.
- RUPT:
  - KYRPTx is held high, and KYxRST is sampled every CLOCK, not gated by TICK.
  - When KYxRST=1: KYRPTx=0, cnt=0, go to RELEASE.
  - KYxRST is ignored outside RUPT, including the edge that enters RUPT; entry wins.
- RELEASE (on TICK only):
  - KEY=0: cnt++.
  - KEY≠0: cnt=0.
  - When cnt reaches DEBOUNCE_TICKS: go to IDLE.
  - A key held through the acknowledge therefore cannot produce a second rupt.
- Overrun: in RUPT, a TICK sample with KEY≠0 and KEY≠CHxx sets KOVRx. KOVRx clears only on rst or GOJAM. CHxx is not overwritten.
- CHxx changes only on PRESS→RUPT. It holds its value through RELEASE and IDLE.
- Counter saturates at DEBOUNCE_TICKS; it never wraps.
- Reset or GOJAM in any state, including mid-debounce: that edge forces IDLE and KYRPTx=0.

Optional Feature:
- Macro: DSKY_KEY_RELEASE_RUPT_EN.
- Defined:
  - On RELEASE→IDLE of keyboard 1, load CH15=00000 and re-assert KYRPT1, entering a fifth state RLSRUPT.
  - KY1RST in RLSRUPT clears KYRPT1 and goes to IDLE.
  - This is a key-release rupt; keyboard 2 is unchanged.
- Undefined: no RLSRUPT state exists and RELEASE goes straight to IDLE.

Decomposition:
- Package dsky_key_pkg: keycode width constant KEY_W=5, state enum (IDLE, PRESS, RUPT, RELEASE, RLSRUPT), code constant KEY_NONE=5'b00000.
- Sub-module dsky_key_debouncer: one FSM, counter and channel register. Instantiated twice; the release-rupt option is enabled by parameter on instance 1 only.
- Top level: wiring, GOJAM/rst merge, overrun outputs.

Test Plan:
- rst, then KEY1=10001 held for 4 TICKs -> CH15=10001 and KYRPT1=1 on the 4th TICK edge; KYRPT2=0, CH16=00000.
- KEY2 bounces 00101,00000,00101 across TICKs -> no rupt. Then 00101 held 4 TICKs -> CH16=00101, KYRPT2=1.
- KYRPT1 high, pulse KY1RST for 1 CLOCK with KEY1 still pressed -> KYRPT1=0 next edge. 10 more TICKs pressed -> no new rupt. Then KEY1=0 for 4 TICKs -> FSM in IDLE.
- While in RUPT with CH15=10001, KEY1=00011 sampled -> KOVR1=1, CH15 remains 10001. GOJAM pulse -> KOVR1=0, KYRPT1=0, CH15 remains 10001.
- KY1RST asserted on the same edge KYRPT1 rises -> KYRPT1 stays 1. KY1RST next cycle -> KYRPT1=0.
- With DSKY_KEY_RELEASE_RUPT_EN: press, acknowledge, release 4 TICKs -> CH15=00000 and KYRPT1=1 again. KY1RST -> 0, FSM in IDLE. Without the macro: no second rupt.
